// File: rtl/radix4_pkg.sv
// rtl/radix4_pkg.sv - shared types and constants for the radix-4 DFT stream engine
package radix4_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int N_PTS = 4;

  // Full growth of a 4-point sum: two extra bits, no scaling.
  function automatic int out_width(input int dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/radix4_kernel.sv
// rtl/radix4_kernel.sv - combinational 4-point DFT butterfly, forward or inverse
module radix4_kernel
  import radix4_pkg::*;
#(
  parameter int DW = 8,
  parameter int OW = out_width(DW)
) (
  input  logic              i_inverse,
  input  logic [4*DW-1:0]   i_re,
  input  logic [4*DW-1:0]   i_im,
  output logic [4*OW-1:0]   o_re,
  output logic [4*OW-1:0]   o_im
);

  logic signed [OW-1:0] w_a [N_PTS];
  logic signed [OW-1:0] w_b [N_PTS];

  for (genvar n = 0; n < N_PTS; n++) begin : g_ext
    assign w_a[n] = {{(OW-DW){i_re[n*DW+DW-1]}}, i_re[n*DW +: DW]};
    assign w_b[n] = {{(OW-DW){i_im[n*DW+DW-1]}}, i_im[n*DW +: DW]};
  end

  logic signed [OW-1:0] w_s02a, w_s13a, w_d02a, w_d13a;
  logic signed [OW-1:0] w_s02b, w_s13b, w_d02b, w_d13b;
  logic signed [OW-1:0] w_x0_re, w_x0_im, w_x2_re, w_x2_im;
  logic signed [OW-1:0] w_p_re, w_p_im, w_m_re, w_m_im;

  assign w_s02a = w_a[0] + w_a[2];
  assign w_s13a = w_a[1] + w_a[3];
  assign w_d02a = w_a[0] - w_a[2];
  assign w_d13a = w_a[1] - w_a[3];
  assign w_s02b = w_b[0] + w_b[2];
  assign w_s13b = w_b[1] + w_b[3];
  assign w_d02b = w_b[0] - w_b[2];
  assign w_d13b = w_b[1] - w_b[3];

  assign w_x0_re = w_s02a + w_s13a;
  assign w_x0_im = w_s02b + w_s13b;
  assign w_x2_re = w_s02a - w_s13a;
  assign w_x2_im = w_s02b - w_s13b;

  // P = (x0-x2) - j(x1-x3), M = (x0-x2) + j(x1-x3)
  assign w_p_re = w_d02a + w_d13b;
  assign w_p_im = w_d02b - w_d13a;
  assign w_m_re = w_d02a - w_d13b;
  assign w_m_im = w_d02b + w_d13a;

  // Inverse swaps the roles of bins 1 and 3.
  assign o_re = i_inverse ? {w_p_re, w_x2_re, w_m_re, w_x0_re}
                          : {w_m_re, w_x2_re, w_p_re, w_x0_re};
  assign o_im = i_inverse ? {w_p_im, w_x2_im, w_m_im, w_x0_im}
                          : {w_m_im, w_x2_im, w_p_im, w_x0_im};

endmodule

// File: rtl/radix4_dft_stream.sv
// rtl/radix4_dft_stream.sv - streaming 4-point DFT: serial load, one-cycle compute, serial drain
module radix4_dft_stream
  import radix4_pkg::*;
#(
  parameter int DW = 8,
  parameter int OW = out_width(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inverse,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_re,
  output logic [OW-1:0] out_im,
  output logic [1:0]    out_idx,
  output logic          out_last
);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_cnt;
  logic              r_inv;
  logic [4*DW-1:0]   r_x_re;
  logic [4*DW-1:0]   r_x_im;
  logic [4*OW-1:0]   r_res_re;
  logic [4*OW-1:0]   r_res_im;
  logic [4*OW-1:0]   w_bin_re;
  logic [4*OW-1:0]   w_bin_im;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_last_fire;
  logic [1:0]        w_ptr;

  radix4_kernel #(.DW(DW), .OW(OW)) u_kernel (
    .i_inverse (r_inv),
    .i_re      (r_x_re),
    .i_im      (r_x_im),
    .o_re      (w_bin_re),
    .o_im      (w_bin_im)
  );

  assign w_in_fire   = in_valid & in_ready & (r_state == LOAD);
  assign w_out_fire  = out_valid & out_ready;
  assign w_last_fire = w_out_fire & out_last;
  // Next bin to present: first bin of the drain, or the one after the bin just taken.
  assign w_ptr       = out_valid ? out_idx + 2'd1 : 2'd0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    if (w_in_fire && r_cnt == 2'(N_PTS-1)) w_next = COMPUTE;
      COMPUTE: w_next = DRAIN;
      DRAIN:   if (w_last_fire) w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_inv     <= 1'b0;
      r_x_re    <= '0;
      r_x_im    <= '0;
      r_res_re  <= '0;
      r_res_im  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      in_ready <= (w_next == LOAD);

      if (w_in_fire) begin
        r_x_re[int'(r_cnt)*DW +: DW] <= in_re;
        r_x_im[int'(r_cnt)*DW +: DW] <= in_im;
        r_cnt <= r_cnt + 2'd1;
        if (r_cnt == 2'd0) r_inv <= inverse;
      end

      if (r_state == COMPUTE) begin
        r_res_re <= w_bin_re;
        r_res_im <= w_bin_im;
      end

      // Output register only advances when empty or when the current bin is taken.
      if (r_state == DRAIN && (!out_valid || out_ready)) begin
        if (w_last_fire) begin
          out_valid <= 1'b0;
          out_idx   <= '0;
          out_last  <= 1'b0;
        end else begin
          out_valid <= 1'b1;
          out_re    <= r_res_re[int'(w_ptr)*OW +: OW];
          out_im    <= r_res_im[int'(w_ptr)*OW +: OW];
          out_idx   <= w_ptr;
          out_last  <= (w_ptr == 2'd3);
        end
      end
    end
  end

endmodule

// File: tb/tb_radix4_dft_stream.sv
// tb/tb_radix4_dft_stream.sv - scoreboard bench for radix4_dft_stream at DW=8 and DW=12
module tb_radix4_dft_stream;

  logic clk = 1'b0;
  logic rst;
  logic inverse;
  logic in_valid;
  logic out_ready;
  logic [7:0]  in8_re, in8_im;
  logic [11:0] in12_re, in12_im;
  logic in_ready8, in_ready12, ov8, ov12, last8, last12;
  logic signed [9:0]  o8_re, o8_im;
  logic signed [13:0] o12_re, o12_im;
  logic [1:0] idx8, idx12;

  always #5 clk = ~clk;

  radix4_dft_stream #(.DW(8)) u_dut8 (
    .clk(clk), .rst(rst), .inverse(inverse), .in_valid(in_valid), .in_ready(in_ready8),
    .in_re(in8_re), .in_im(in8_im), .out_valid(ov8), .out_ready(out_ready),
    .out_re(o8_re), .out_im(o8_im), .out_idx(idx8), .out_last(last8)
  );

  radix4_dft_stream #(.DW(12)) u_dut12 (
    .clk(clk), .rst(rst), .inverse(inverse), .in_valid(in_valid), .in_ready(in_ready12),
    .in_re(in12_re), .in_im(in12_im), .out_valid(ov12), .out_ready(out_ready),
    .out_re(o12_re), .out_im(o12_im), .out_idx(idx12), .out_last(last12)
  );

  typedef struct {
    int re8, im8, re12, im12, idx;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int ready_mode = 0;
  int stall_left = 0;
  bit hold = 0;
  bit prev_ov = 0;
  int h_re, h_im, h_idx;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  // Direct DFT sum with twiddle powers of -j (forward) or +j (inverse).
  function automatic void dft(input int re[4], input int im[4], input bit inv,
                              output int ore[4], output int oim[4]);
    for (int k = 0; k < 4; k++) begin
      int sr = 0;
      int si = 0;
      for (int n = 0; n < 4; n++) begin
        int m = inv ? (n * k) % 4 : (3 * n * k) % 4;
        case (m)
          0: begin sr += re[n]; si += im[n]; end
          1: begin sr -= im[n]; si += re[n]; end
          2: begin sr -= re[n]; si -= im[n]; end
          default: begin sr += im[n]; si -= re[n]; end
        endcase
      end
      ore[k] = sr;
      oim[k] = si;
    end
  endfunction

  // Output-side ready pattern, updated just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 99) < 70);
        default: begin
          if (ov8 && idx8 == 2'd1 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
      prev_ov = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", int'(ov8), 1);
        chk("hold_re", int'(o8_re), h_re);
        chk("hold_im", int'(o8_im), h_im);
        chk("hold_idx", int'(idx8), h_idx);
      end
      if (ov8) begin
        chk("in_ready_low_in_drain", int'(in_ready8), 0);
        chk("valid12_with_valid8", int'(ov12), 1);
        if (!prev_ov) chk("latency", cyc - acc_cyc, 2);
      end
      if (ov8 && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_bin", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("re8", int'(o8_re), e.re8);
          chk("im8", int'(o8_im), e.im8);
          chk("re12", int'(o12_re), e.re12);
          chk("im12", int'(o12_im), e.im12);
          chk("idx", int'(idx8), e.idx);
          chk("idx12", int'(idx12), e.idx);
          chk("last", int'(last8), int'(e.idx == 3));
        end
      end
      hold = ov8 && !out_ready;
      h_re = int'(o8_re);
      h_im = int'(o8_im);
      h_idx = int'(idx8);
      prev_ov = ov8;
    end
  end

  task automatic send_sample(input int r8, input int i8, input int r12, input int i12,
                             input bit inv_bit, input int idle_max);
    int guard = 0;
    repeat ($urandom_range(0, idle_max)) @(negedge clk);
    in_valid = 1'b1;
    inverse  = inv_bit;
    in8_re = 8'(r8);   in8_im = 8'(i8);
    in12_re = 12'(r12); in12_im = 12'(i12);
    while (!in_ready8 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      failures++;
      $display("FAIL in_ready_timeout actual=0 expected=1");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "in_ready never asserted");
    end
    acc_cyc = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    inverse  = $urandom_range(0, 1);
  endtask

  task automatic send_frame(input int r8[4], input int i8[4], input int r12[4], input int i12[4],
                            input bit inv, input bit tog, input int idle_max);
    int e8r[4], e8i[4], e12r[4], e12i[4];
    for (int n = 0; n < 4; n++) begin
      bit ib;
      ib = (n == 0) ? inv : (tog ? ~inv : 1'($urandom_range(0, 1)));
      send_sample(r8[n], i8[n], r12[n], i12[n], ib, idle_max);
    end
    dft(r8, i8, inv, e8r, e8i);
    dft(r12, i12, inv, e12r, e12i);
    for (int k = 0; k < 4; k++) q.push_back('{e8r[k], e8i[k], e12r[k], e12i[k], k});
  endtask

  task automatic rand_frame(output int r8[4], output int i8[4], output int r12[4], output int i12[4]);
    for (int n = 0; n < 4; n++) begin
      r8[n]  = int'($urandom_range(0, 255)) - 128;
      i8[n]  = int'($urandom_range(0, 255)) - 128;
      r12[n] = int'($urandom_range(0, 4095)) - 2048;
      i12[n] = int'($urandom_range(0, 4095)) - 2048;
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((q.size() != 0 || ov8) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    int r8[4], i8[4], r12[4], i12[4], z[4], ramp[4], fs8[4], fs12[4], imp[4];
    z = '{0, 0, 0, 0};
    ramp = '{1, 2, 3, 4};
    imp = '{1, 0, 0, 0};
    fs8 = '{-128, -128, -128, -128};
    fs12 = '{-2048, -2048, -2048, -2048};
    rst = 1'b1; in_valid = 1'b0; inverse = 1'b0;
    in8_re = '0; in8_im = '0; in12_re = '0; in12_im = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready8), 1);
    chk("rst_out_valid", int'(ov8), 0);
    chk("rst_out_re", int'(o8_re), 0);
    chk("rst_out_im", int'(o8_im), 0);
    chk("rst_out_idx", int'(idx8), 0);
    chk("rst_out_last", int'(last8), 0);
    chk("rst_in_ready12", int'(in_ready12), 1);
    chk("rst_out_valid12", int'(ov12), 0);
    rst = 1'b0;

    send_frame(imp, z, imp, z, 1'b0, 1'b0, 0);
    wait_drain();
    send_frame(ramp, z, ramp, z, 1'b0, 1'b0, 0);
    wait_drain();
    send_frame(ramp, z, ramp, z, 1'b1, 1'b1, 0);
    wait_drain();
    send_frame(fs8, fs8, fs12, fs12, 1'b0, 1'b0, 0);
    wait_drain();

    ready_mode = 2;
    stall_left = 5;
    rand_frame(r8, i8, r12, i12);
    send_frame(r8, i8, r12, i12, 1'b0, 1'b0, 0);
    wait_drain();
    ready_mode = 0;

    send_sample(7, -3, 900, -77, 1'b1, 0);
    send_sample(-5, 11, -1500, 321, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midframe_rst_in_ready", int'(in_ready8), 1);
    chk("midframe_rst_out_valid", int'(ov8), 0);
    send_frame(ramp, ramp, ramp, ramp, 1'b0, 1'b0, 0);
    wait_drain();

    ready_mode = 1;
    for (int f = 0; f < 40; f++) begin
      rand_frame(r8, i8, r12, i12);
      send_frame(r8, i8, r12, i12, 1'($urandom_range(0, 1)), 1'b0, 2);
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
